reg_mask_encoder: RTL and testbench

//  Inverse of the register write-enable decoder: accepts a 32-bit one-bit-per-register

---
 rtl/reg_mask_encoder_pkg.sv | 14 +
 rtl/reg_prio_enc.sv | 21 ++
 rtl/reg_mask_encoder.sv | 104 ++++++++++
 tb/tb_reg_mask_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_mask_encoder_pkg.sv
// Shared definitions for the register-mask encoder: register file geometry
// and the encoder state encoding.
package reg_mask_encoder_pkg;

  localparam int REG_NUM = 32;
  localparam int REG_IW  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } encState_t;

endpackage

// File: rtl/reg_prio_enc.sv
// Lowest-set-bit priority encoder. Purely combinational; idx is 0 when the
// input is empty, so callers qualify it with any.
module reg_prio_enc #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] iVec,
  output logic [W-1:0] oIdx,
  output logic         oAny
);

  // Scan from the top down so the lowest set bit is the last assignment to win.
  always_comb begin
    oIdx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (iVec[i]) oIdx = W'(i);
    end
    oAny = |iVec;
  end

endmodule

// File: rtl/reg_mask_encoder.sv
// Drains a one-bit-per-register mask as a stream of register indices, lowest
// index first, one index per accepted handshake.
//
// Handshake: oIdx is offered while oValid=1 and is consumed on a cycle where
// oValid=1 and iReady=1; while iReady=0 the offer (oValid, oIdx) stays
// unchanged, and oIdx reads 0 whenever oValid=0.
module reg_mask_encoder
  import reg_mask_encoder_pkg::*;
#(
  parameter int NREG    = REG_NUM,
  parameter int IW      = REG_IW,
  parameter bit SKIP_R0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREG-1:0] iMask,
  input  logic            iLoad,
  input  logic            iClear,
  input  logic            iReady,
  output logic [IW-1:0]   oIdx,
  output logic            oValid,
  output logic            oBusy,
  output logic            oDone
);

  encState_t       state;
  encState_t       stateNext;
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pendNext;
  logic [NREG-1:0] loadMask;
  logic [NREG-1:0] pendCleared;
  logic [IW-1:0]   encIdx;
  logic            encAny;

  reg_prio_enc #(
    .N (NREG),
    .W (IW)
  ) uPrioEnc (
    .iVec (pend),
    .oIdx (encIdx),
    .oAny (encAny)
  );

  // Mask as captured on load ($zero dropped when configured) and pend with the
  // currently offered index removed.
  always_comb begin
    loadMask = iMask;
    if (SKIP_R0) loadMask[0] = 1'b0;
    pendCleared = pend & ~(NREG'(1) << encIdx);
  end

  // State and pending-mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pend  <= '0;
    end else begin
      state <= stateNext;
      pend  <= pendNext;
    end
  end

  // Next state: clear wins over everything, loads only land in IDLE.
  always_comb begin
    stateNext = state;
    pendNext  = pend;
    if (iClear) begin
      stateNext = ST_IDLE;
      pendNext  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iLoad) begin
            pendNext  = loadMask;
            stateNext = (|loadMask) ? ST_SCAN : ST_DONE;
          end
        end
        ST_SCAN: begin
          if (iReady) begin
            pendNext  = pendCleared;
            stateNext = (|pendCleared) ? ST_SCAN : ST_DONE;
          end
        end
        ST_DONE: begin
          stateNext = ST_IDLE;
          pendNext  = '0;
        end
        default: begin
          stateNext = ST_IDLE;
          pendNext  = '0;
        end
      endcase
    end
  end

  // Outputs decoded from state; oIdx is forced to 0 when nothing is offered.
  always_comb begin
    oValid = (state == ST_SCAN) && encAny;
    oIdx   = oValid ? encIdx : '0;
    oBusy  = (state == ST_SCAN) || (state == ST_DONE);
    oDone  = (state == ST_DONE);
  end

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Bench for reg_mask_encoder. Two instances share every input: dut1 skips
// register 0, dut0 does not. Each has its own expected-index queue and
// expected-done count, drained by a negedge monitor.
module tb_reg_mask_encoder;

  localparam int W = 5;

  logic          clk;
  logic          rst_n;
  logic [31:0]   iMask;
  logic          iLoad;
  logic          iClear;
  logic          iReady;
  logic [W-1:0]  oIdx1, oIdx0;
  logic          oValid1, oValid0;
  logic          oBusy1, oBusy0;
  logic          oDone1, oDone0;

  logic [W-1:0]  exp_q1[$];
  logic [W-1:0]  exp_q0[$];
  int            doneExp1;
  int            doneExp0;
  int            checks;
  int            errors;
  logic          holdPend1;
  logic [W-1:0]  holdIdx1;

  reg_mask_encoder #(.NREG(32), .IW(W), .SKIP_R0(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .iMask(iMask), .iLoad(iLoad), .iClear(iClear),
    .iReady(iReady), .oIdx(oIdx1), .oValid(oValid1), .oBusy(oBusy1), .oDone(oDone1)
  );

  reg_mask_encoder #(.NREG(32), .IW(W), .SKIP_R0(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .iMask(iMask), .iLoad(iLoad), .iClear(iClear),
    .iReady(iReady), .oIdx(oIdx0), .oValid(oValid0), .oBusy(oBusy0), .oDone(oDone0)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Expected indices of a load for both instances, plus one done each.
  task automatic pushMask(input logic [31:0] m);
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        exp_q0.push_back(W'(i));
        if (i != 0) exp_q1.push_back(W'(i));
      end
    end
    doneExp1++;
    doneExp0++;
  endtask

  // Load pulse; returns one cycle after the load edge (first offer visible).
  task automatic loadMask(input logic [31:0] m);
    @(posedge clk); #1;
    iMask = m;
    iLoad = 1'b1;
    @(posedge clk); #1;
    iLoad = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int maxCycles, input bit toggleReady);
    int c;
    c = 0;
    while ((oBusy1 || oBusy0) && c < maxCycles) begin
      @(posedge clk); #1;
      if (toggleReady) iReady = ~iReady;
      c++;
    end
    checkVal(tag, {30'd0, oBusy1, oBusy0}, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_1"}, {oIdx1, oValid1, oBusy1, oDone1}, 32'd0);
    checkVal({tag, "_0"}, {oIdx0, oValid0, oBusy0, oDone0}, 32'd0);
  endtask

  // Monitor: consume handshakes and done pulses against the expected queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (holdPend1) begin
        checkVal("hold1_valid", oValid1, 1);
        checkVal("hold1_idx", oIdx1, holdIdx1);
      end
      holdPend1 = oValid1 && !iReady;
      holdIdx1  = oIdx1;
      if (oValid1 && iReady) begin
        checkVal("idx1_avail", (exp_q1.size() > 0), 1);
        if (exp_q1.size() > 0) checkVal("idx1", oIdx1, exp_q1.pop_front());
      end else if (!oValid1) begin
        checkVal("idx1_zero", oIdx1, 0);
      end
      if (oValid0 && iReady) begin
        checkVal("idx0_avail", (exp_q0.size() > 0), 1);
        if (exp_q0.size() > 0) checkVal("idx0", oIdx0, exp_q0.pop_front());
      end else if (!oValid0) begin
        checkVal("idx0_zero", oIdx0, 0);
      end
      if (oDone1) begin
        checkVal("done1_expected", (doneExp1 > 0), 1);
        checkVal("done1_drained", exp_q1.size(), 0);
        if (doneExp1 > 0) doneExp1--;
      end
      if (oDone0) begin
        checkVal("done0_expected", (doneExp0 > 0), 1);
        checkVal("done0_drained", exp_q0.size(), 0);
        if (doneExp0 > 0) doneExp0--;
      end
    end else begin
      holdPend1 = 1'b0;
    end
  end

  initial begin
    logic [31:0] m;
    checks    = 0;
    errors    = 0;
    doneExp1  = 0;
    doneExp0  = 0;
    holdPend1 = 1'b0;
    rst_n     = 1'b0;
    iMask     = '0;
    iLoad     = 1'b0;
    iClear    = 1'b0;
    iReady    = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkAllZero("post_reset");

    // Sparse mask: indices 1,4,15 back to back, then one done
    pushMask(32'h0000_8012);
    loadMask(32'h0000_8012);
    checkVal("seq_v0", {oValid1, 27'd0, oIdx1}, {1'b1, 27'd0, 5'd1});
    @(posedge clk); #1;
    checkVal("seq_v1", {oValid1, 27'd0, oIdx1}, {1'b1, 27'd0, 5'd4});
    @(posedge clk); #1;
    checkVal("seq_v2", {oValid1, 27'd0, oIdx1}, {1'b1, 27'd0, 5'd15});
    @(posedge clk); #1;
    checkVal("seq_done", {oDone1, oValid1, oBusy1}, 3'b101);
    @(posedge clk); #1;
    checkVal("seq_idle", {oDone1, oBusy1}, 2'b00);

    // Mask holding only bit 0: dut1 sees empty load, dut0 issues index 0
    pushMask(32'h0000_0001);
    loadMask(32'h0000_0001);
    checkVal("r0_done1", {oDone1, oValid1}, 2'b10);
    checkVal("r0_valid0", {oValid0, 27'd0, oIdx0}, {1'b1, 27'd0, 5'd0});
    @(posedge clk); #1;
    checkVal("r0_idle1", oBusy1, 0);
    waitIdle("r0_timeout", 10, 1'b0);

    // Empty mask: immediate done on both
    pushMask(32'h0);
    loadMask(32'h0);
    checkVal("empty_done", {oDone1, oValid1, oDone0, oValid0}, 4'b1010);
    waitIdle("empty_timeout", 10, 1'b0);

    // Full mask with iReady toggling every cycle
    pushMask(32'hFFFF_FFFF);
    loadMask(32'hFFFF_FFFF);
    waitIdle("full_timeout", 200, 1'b1);
    iReady = 1'b1;

    // Load while busy is ignored
    iReady = 1'b0;
    pushMask(32'h0000_000C);
    loadMask(32'h0000_000C);
    iMask = 32'h0000_00F0;
    iLoad = 1'b1;
    @(posedge clk); #1;
    iLoad  = 1'b0;
    iReady = 1'b1;
    waitIdle("busyload_timeout", 20, 1'b0);

    // Clear on the second handshake: 9,10 delivered, 11 dropped, no done
    exp_q1.push_back(5'd9);  exp_q1.push_back(5'd10);
    exp_q0.push_back(5'd9);  exp_q0.push_back(5'd10);
    loadMask(32'h0000_0E00);
    @(posedge clk); #1;
    iClear = 1'b1;
    @(posedge clk); #1;
    iClear = 1'b0;
    checkAllZero("clear_idle");
    @(posedge clk); #1;
    checkVal("clear_no_done", {oDone1, oDone0}, 2'b00);
    // Clear together with load stays idle
    iMask  = 32'h0000_0030;
    iLoad  = 1'b1;
    iClear = 1'b1;
    @(posedge clk); #1;
    iLoad  = 1'b0;
    iClear = 1'b0;
    checkAllZero("clear_load");

    // Random masks with random back-pressure
    for (int t = 0; t < 6; t++) begin
      m = {$urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF)};
      if (t == 0) m = 32'h8000_0001;
      pushMask(m);
      loadMask(m);
      for (int c = 0; c < 150 && (oBusy1 || oBusy0); c++) begin
        iReady = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      iReady = 1'b1;
      waitIdle("rand_timeout", 5, 1'b0);
    end

    // Reset in the middle of a sequence
    pushMask(32'hFFFF_FFFF);
    loadMask(32'hFFFF_FFFF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("mid_reset");
    exp_q1.delete();
    exp_q0.delete();
    doneExp1 = 0;
    doneExp0 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkAllZero("after_mid_reset");

    // Everything expected was seen
    repeat (2) @(posedge clk);
    #1;
    checkVal("q1_left", exp_q1.size(), 0);
    checkVal("q0_left", exp_q0.size(), 0);
    checkVal("done1_left", doneExp1, 0);
    checkVal("done0_left", doneExp0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
